fill_rect_cmd_decode_engine: RTL and testbench

//  Upstream stage of fill_rect_data_gen_engine. Assembles 3-word FILL_RECT commands from the command stream and clips them to the screen.

---
 rtl/fill_rect_cmd_decode_engine.sv | 175 +++++++++++++++++
 tb/tb_fill_rect_cmd_decode_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fill_rect_cmd_decode_engine.sv
// fill_rect_cmd_decode_engine
//   Front end of the fill-rect data generator. Assembles 3-word FILL_RECT
//   commands, clips them to the screen, computes the first frame-buffer word
//   address and hands the result to the generator over rts/rtr.
//   Output fields are double-buffered. They change only on the hand-over edge,
//   so the generator can keep reading colours while it draws.
// Ports
//   clk, rst_         clock, asynchronous active-low reset
//   cmd_in_data/rts   command word stream in
//   cmd_in_rtr        ready for a command word (registered)
//   out_rts           command valid to the generator
//   in_rtr            generator ready
//   init_addr         first word address of the rectangle
//   cmd_data_hgt/wid  clipped rectangle size
//   cmd_data_r/g/bval colour
//   cmd_err           one-cycle pulse when a command is dropped
//   cmd_count         commands handed over, wraps 255->0
module fill_rect_cmd_decode_engine #(
    parameter logic [3:0]  OPCODE_FILL = 4'h1,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 272,
    parameter int          ROW_STRIDE  = 240,
    parameter logic [15:0] BASE_ADDR   = 16'h0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [31:0] cmd_in_data,
    input  logic        cmd_in_rts,
    output logic        cmd_in_rtr,
    output logic        out_rts,
    input  logic        in_rtr,
    output logic [15:0] init_addr,
    output logic [15:0] cmd_data_hgt,
    output logic [15:0] cmd_data_wid,
    output logic [3:0]  cmd_data_rval,
    output logic [3:0]  cmd_data_gval,
    output logic [3:0]  cmd_data_bval,
    output logic        cmd_err,
    output logic [7:0]  cmd_count
);

    typedef enum logic [2:0] {IDLE, W0, W1, W2, CALC, PEND} state_t;

    localparam logic [16:0] SW17 = 17'(SCREEN_W);
    localparam logic [16:0] SH17 = 17'(SCREEN_H);
    localparam logic [15:0] SW16 = 16'(SCREEN_W);
    localparam logic [15:0] SH16 = 16'(SCREEN_H);
    localparam logic [15:0] RS16 = 16'(ROW_STRIDE);

    state_t      state;
    logic        valid;

    // Staging for the command being assembled. Only x[11:3] is kept because
    // x is always rounded down to an 8-pixel boundary.
    logic [8:0]  stg_xh;
    logic [11:0] stg_y;
    logic [15:0] stg_wid, stg_hgt;
    logic [11:0] stg_rgb;

    // Staging for the computed result waiting in PEND
    logic [15:0] res_addr, res_wid, res_hgt;
    logic [11:0] res_rgb;

    logic        xfer;
    logic [11:0] xa;
    logic [16:0] x_end, y_end;
    logic        drop;
    logic [15:0] wid_c, hgt_c, addr_c;

    assign xfer = cmd_in_rts & cmd_in_rtr;

    // The generator captures in_rts in any idle cycle, so out_rts must never
    // be raised while in_rtr is low.
    assign out_rts = (state == PEND) & valid & in_rtr;

    // Clip and address math. The 17-bit ends prevent the sums from wrapping.
    always_comb begin
        xa     = {stg_xh, 3'b000};
        x_end  = {5'b0, xa} + {1'b0, stg_wid};
        y_end  = {5'b0, stg_y} + {1'b0, stg_hgt};
        drop   = (stg_wid == 16'd0) | (stg_hgt == 16'd0) |
                 ({5'b0, xa} >= SW17) | ({5'b0, stg_y} >= SH17);
        // When drop is 0, xa < SCREEN_W and y < SCREEN_H, so the
        // subtractions cannot underflow.
        wid_c  = (x_end > SW17) ? (SW16 - {4'b0, xa})    : stg_wid;
        hgt_c  = (y_end > SH17) ? (SH16 - {4'b0, stg_y}) : stg_hgt;
        addr_c = BASE_ADDR + {4'b0, stg_y} * RS16 + {7'b0, stg_xh} * 16'd3;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state         <= IDLE;
            valid         <= 1'b0;
            cmd_in_rtr    <= 1'b0;
            cmd_err       <= 1'b0;
            cmd_count     <= 8'd0;
            stg_xh        <= '0;
            stg_y         <= '0;
            stg_wid       <= '0;
            stg_hgt       <= '0;
            stg_rgb       <= '0;
            res_addr      <= '0;
            res_wid       <= '0;
            res_hgt       <= '0;
            res_rgb       <= '0;
            init_addr     <= '0;
            cmd_data_hgt  <= '0;
            cmd_data_wid  <= '0;
            cmd_data_rval <= '0;
            cmd_data_gval <= '0;
            cmd_data_bval <= '0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= W0;
                    cmd_in_rtr <= 1'b1;
                end
                W0: if (xfer) begin
                    // A word with the wrong opcode is discarded on its own.
                    // The next word is parsed as word0 again.
                    if (cmd_in_data[31:28] != OPCODE_FILL) begin
                        cmd_err <= 1'b1;
                    end else begin
                        stg_xh <= cmd_in_data[11:3];
                        stg_y  <= cmd_in_data[23:12];
                        state  <= W1;
                    end
                end
                W1: if (xfer) begin
                    stg_hgt <= cmd_in_data[31:16];
                    stg_wid <= cmd_in_data[15:0];
                    state   <= W2;
                end
                W2: if (xfer) begin
                    stg_rgb    <= cmd_in_data[11:0];
                    state      <= CALC;
                    cmd_in_rtr <= 1'b0;
                end
                CALC: begin
                    if (drop) begin
                        cmd_err    <= 1'b1;
                        valid      <= 1'b0;
                        state      <= W0;
                        cmd_in_rtr <= 1'b1;
                    end else begin
                        res_addr <= addr_c;
                        res_wid  <= wid_c;
                        res_hgt  <= hgt_c;
                        res_rgb  <= stg_rgb;
                        valid    <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: if (out_rts) begin
                    init_addr     <= res_addr;
                    cmd_data_hgt  <= res_hgt;
                    cmd_data_wid  <= res_wid;
                    cmd_data_rval <= res_rgb[11:8];
                    cmd_data_gval <= res_rgb[7:4];
                    cmd_data_bval <= res_rgb[3:0];
                    cmd_count     <= cmd_count + 8'd1;
                    valid         <= 1'b0;
                    state         <= W0;
                    cmd_in_rtr    <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    cmd_in_rtr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_rect_cmd_decode_engine.sv
// Directed bench for fill_rect_cmd_decode_engine. Inputs change 2 ns after a
// rising edge. Outputs are sampled on falling edges or mid-cycle.
module tb_fill_rect_cmd_decode_engine;

    logic        clk = 1'b0;
    logic        rst_;
    logic [31:0] cmd_in_data;
    logic        cmd_in_rts;
    logic        cmd_in_rtr;
    logic        out_rts;
    logic        in_rtr;
    logic [15:0] init_addr, cmd_data_hgt, cmd_data_wid;
    logic [3:0]  cmd_data_rval, cmd_data_gval, cmd_data_bval;
    logic        cmd_err;
    logic [7:0]  cmd_count;

    int total = 0;
    int bad   = 0;
    int n_rts = 0;
    int n_err = 0;
    int rts0, err0;

    always #5 clk = ~clk;

    fill_rect_cmd_decode_engine dut (
        .clk          (clk),
        .rst_         (rst_),
        .cmd_in_data  (cmd_in_data),
        .cmd_in_rts   (cmd_in_rts),
        .cmd_in_rtr   (cmd_in_rtr),
        .out_rts      (out_rts),
        .in_rtr       (in_rtr),
        .init_addr    (init_addr),
        .cmd_data_hgt (cmd_data_hgt),
        .cmd_data_wid (cmd_data_wid),
        .cmd_data_rval(cmd_data_rval),
        .cmd_data_gval(cmd_data_gval),
        .cmd_data_bval(cmd_data_bval),
        .cmd_err      (cmd_err),
        .cmd_count    (cmd_count)
    );

    // Count the cycles each pulse output is high
    always @(negedge clk) begin
        if (out_rts) n_rts++;
        if (cmd_err) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Present one word, then wait until it is accepted (bounded wait)
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        cmd_in_data = w;
        cmd_in_rts  = 1'b1;
        @(negedge clk);
        while (!cmd_in_rtr && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #2;
        cmd_in_rts = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        send_word(w0);
        send_word(w1);
        send_word(w2);
    endtask

    task automatic chk_fields(input string tag, input logic [15:0] a, input logic [15:0] h,
                              input logic [15:0] w, input logic [11:0] rgb);
        chk({tag, "_addr"}, 32'(init_addr), 32'(a));
        chk({tag, "_hgt"},  32'(cmd_data_hgt), 32'(h));
        chk({tag, "_wid"},  32'(cmd_data_wid), 32'(w));
        chk({tag, "_rgb"},  32'({cmd_data_rval, cmd_data_gval, cmd_data_bval}), 32'(rgb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0; in_rtr = 1'b0; cmd_in_rts = 1'b0; cmd_in_data = '0;
        tick(2);

        // 1: reset values
        chk("rst_rtr", 32'(cmd_in_rtr), 0);
        chk("rst_rts", 32'(out_rts), 0);
        chk("rst_err", 32'(cmd_err), 0);
        chk("rst_count", 32'(cmd_count), 0);
        chk_fields("rst", 16'd0, 16'd0, 16'd0, 12'h000);
        rst_ = 1'b1;
        @(negedge clk);
        chk("rtr_first_cycle", 32'(cmd_in_rtr), 0);
        tick(1);
        chk("rtr_after_idle", 32'(cmd_in_rtr), 1);

        // 2: basic fill and latency
        in_rtr = 1'b1;
        rts0 = n_rts;
        send_cmd(32'h1000_2010, 32'h0003_0004, 32'h0000_0A5F);
        @(negedge clk);
        chk("calc_no_rts", 32'(out_rts), 0);
        @(negedge clk);
        chk("pend_rts", 32'(out_rts), 1);
        tick(3);
        chk("basic_rts_pulses", 32'(n_rts - rts0), 1);
        chk_fields("basic", 16'd486, 16'd3, 16'd4, 12'hA5F);
        chk("basic_count", 32'(cmd_count), 1);

        // 3: clip at the right and bottom edges
        send_cmd(32'h1000_027B, 32'h012C_0010, 32'h0000_0123);
        tick(4);
        chk_fields("clip", 16'd237, 16'd272, 16'd8, 12'h123);
        chk("clip_count", 32'(cmd_count), 2);

        // 4: bad opcode, zero height, x at the screen edge
        rts0 = n_rts; err0 = n_err;
        send_word(32'h7000_0000);
        tick(2);
        chk("badop_err", 32'(n_err - err0), 1);
        send_cmd(32'h1000_0000, 32'h0000_0005, 32'h0000_0FFF);
        tick(3);
        chk("hgt0_err", 32'(n_err - err0), 2);
        send_cmd(32'h1000_0280, 32'h0001_0001, 32'h0000_0FFF);
        tick(3);
        chk("xedge_err", 32'(n_err - err0), 3);
        chk("drop_no_rts", 32'(n_rts - rts0), 0);
        chk("drop_count", 32'(cmd_count), 2);
        chk("drop_addr_kept", 32'(init_addr), 237);

        // 5: back-pressure for 50 cycles
        in_rtr = 1'b0;
        rts0 = n_rts;
        send_cmd(32'h1000_1008, 32'h0001_0002, 32'h0000_0456);
        tick(50);
        chk("bp_no_rts", 32'(n_rts - rts0), 0);
        chk("bp_rtr_low", 32'(cmd_in_rtr), 0);
        chk_fields("bp_hold", 16'd237, 16'd272, 16'd8, 12'h123);
        chk("bp_count", 32'(cmd_count), 2);
        in_rtr = 1'b1;
        tick(3);
        chk("bp_one_rts", 32'(n_rts - rts0), 1);
        chk_fields("bp_go", 16'd243, 16'd1, 16'd2, 12'h456);
        chk("bp_go_count", 32'(cmd_count), 3);

        // 6: reset in mid-command, then recovery and count wrap
        send_word(32'h1000_2010);
        send_word(32'h0003_0004);
        rst_ = 1'b0;
        #3;
        chk("mid_rst_count", 32'(cmd_count), 0);
        chk("mid_rst_rtr", 32'(cmd_in_rtr), 0);
        chk("mid_rst_rts", 32'(out_rts), 0);
        chk_fields("mid_rst", 16'd0, 16'd0, 16'd0, 12'h000);
        tick(2);
        rst_ = 1'b1;
        send_cmd(32'h1010_F000, 32'h0005_0280, 32'h0000_0789);
        tick(4);
        chk_fields("post_rst", 16'd65040, 16'd1, 16'd640, 12'h789);
        chk("post_rst_count", 32'(cmd_count), 1);

        for (int i = 0; i < 254; i++)
            send_cmd(32'h1000_0000, 32'h0001_0001, 32'h0000_0000);
        tick(4);
        chk("count_255", 32'(cmd_count), 255);
        send_cmd(32'h1000_0000, 32'h0001_0001, 32'h0000_0000);
        tick(4);
        chk("count_wrap", 32'(cmd_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
